// File: rtl/frame_ram_port_arbiter_if.sv
// Requester-side bus of the frame-RAM port-B arbiter: flattened per-requester
// request/lock/write/address/data lanes plus one-hot grant and read-return strobes.
interface frame_ram_port_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 18,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    lock;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rd_valid;
  logic [DW-1:0]       rd_data;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rd_valid, rd_data
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rd_valid, rd_data
  );
endinterface

// File: rtl/frame_ram_port_arbiter.sv
// Round-robin owner arbiter for frame-RAM port B with locked bursts and tagged read return.
// Optional grant watchdog enabled by defining ARB_WATCHDOG_EN.
module frame_ram_port_arbiter #(
  parameter int N_REQ    = 4,
  parameter int AW       = 18,
  parameter int DW       = 8,
  parameter int RD_LAT   = 2,
  parameter int MAX_HOLD = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  frame_ram_port_arbiter_if.slave req_bus,
  output logic                   ram_enb_o,
  output logic                   ram_web_o,
  output logic [AW-1:0]          ram_addrb_o,
  output logic [DW-1:0]          ram_dinb_o,
  input  logic [DW-1:0]          ram_doutb_i,
  output logic                   busy_o,
  output logic [2:0]             owner_id_o,
  output logic                   err_hold_o
);

  typedef enum logic {S_IDLE, S_OWN} state_e;

  state_e            state_q, state_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic              ram_enb_q, ram_enb_d;
  logic              ram_web_q, ram_web_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [DW-1:0]     ram_din_q, ram_din_d;
  logic [RD_LAT:0]   tag_vld_q;
  logic [2:0]        tag_id_q [RD_LAT+1];

  logic [N_REQ-1:0]  owner_oh;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  rd_valid;
  logic              own_req, own_lock, own_we;
  logic [AW-1:0]     own_addr;
  logic [DW-1:0]     own_wdata;
  logic              pick_found;
  logic [2:0]        pick_idx;
  logic              grant, rel;
  logic              hold_hit;

  always_comb begin
    owner_oh  = '0;
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_oh[i] = (owner_q == 3'(i));
      if (owner_q == 3'(i)) begin
        own_addr  = req_bus.addr[i*AW +: AW];
        own_wdata = req_bus.wdata[i*DW +: DW];
      end
    end
    own_req  = |(req_bus.req  & owner_oh);
    own_lock = |(req_bus.lock & owner_oh);
    own_we   = |(req_bus.we   & owner_oh);
  end

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pick_found && req_bus.req[i] && (((int'(rr_ptr_q) + k) % N_REQ) == i)) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    gnt        = '0;
    grant      = 1'b0;
    rel        = 1'b0;
    ram_enb_d  = 1'b0;
    ram_web_d  = ram_web_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_OWN;
          owner_d = pick_idx;
        end
      end
      S_OWN: begin
        if (own_req) begin
          grant      = 1'b1;
          gnt        = owner_oh;
          ram_enb_d  = 1'b1;
          ram_web_d  = own_we;
          ram_addr_d = own_addr;
          ram_din_d  = own_wdata;
          rel        = ~own_lock | hold_hit;
        end else begin
          rel = 1'b1;
        end
        if (rel) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == 3'(N_REQ-1)) ? 3'd0 : owner_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      ram_enb_q  <= 1'b0;
      ram_web_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      tag_vld_q  <= '0;
      for (int s = 0; s <= RD_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      ram_enb_q  <= ram_enb_d;
      ram_web_q  <= ram_web_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      // Stage 0 lines up with the registered enb; the last stage lines up with doutb.
      tag_vld_q   <= {tag_vld_q[RD_LAT-1:0], grant & ~own_we};
      tag_id_q[0] <= owner_q;
      for (int s = 1; s <= RD_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
    end
  end

  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rd_valid[i] = tag_vld_q[RD_LAT] && (tag_id_q[RD_LAT] == 3'(i));
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       err_hold_q;
  logic       forced_rel;

  assign hold_hit   = (hold_cnt_q == HOLD_LAST);
  assign forced_rel = grant & own_lock & hold_hit;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == S_IDLE) begin
      hold_cnt_d = '0;
    end else if (grant && (hold_cnt_q != 8'hFF)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      err_hold_q <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      err_hold_q <= forced_rel;
    end
  end

  assign err_hold_o = err_hold_q;
`else
  logic unused_max_hold;

  assign hold_hit        = 1'b0;
  assign err_hold_o      = 1'b0;
  assign unused_max_hold = (MAX_HOLD > 0);
`endif

  assign req_bus.gnt      = gnt;
  assign req_bus.rd_valid = rd_valid;
  assign req_bus.rd_data  = tag_vld_q[RD_LAT] ? ram_doutb_i : '0;

  assign ram_enb_o   = ram_enb_q;
  assign ram_web_o   = ram_web_q;
  assign ram_addrb_o = ram_addr_q;
  assign ram_dinb_o  = ram_din_q;
  assign busy_o      = (state_q == S_OWN);
  assign owner_id_o  = owner_q;

endmodule

// File: tb/tb_frame_ram_port_arbiter.sv
// Directed bench for frame_ram_port_arbiter with a behavioural 2-cycle-latency RAM model.
module tb_frame_ram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ram_enb, ram_web;
  logic [17:0] ram_addrb;
  logic [7:0]  ram_dinb, ram_doutb;
  logic        busy, err_hold;
  logic [2:0]  owner_id;

  int n_vec = 0;
  int n_err = 0;

  frame_ram_port_arbiter_if #(.N_REQ(4), .AW(18), .DW(8)) bus_if ();

  frame_ram_port_arbiter #(
    .N_REQ(4), .AW(18), .DW(8), .RD_LAT(2), .MAX_HOLD(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_bus     (bus_if),
    .ram_enb_o   (ram_enb),
    .ram_web_o   (ram_web),
    .ram_addrb_o (ram_addrb),
    .ram_dinb_o  (ram_dinb),
    .ram_doutb_i (ram_doutb),
    .busy_o      (busy),
    .owner_id_o  (owner_id),
    .err_hold_o  (err_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<18)-1];
  logic [7:0] p1, p2;
  assign ram_doutb = p2;

  always @(posedge clk) begin
    if (ram_enb) begin
      if (ram_web) mem[ram_addrb] <= ram_dinb;
      else         p1 <= mem[ram_addrb];
    end
    p2 <= p1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [17:0] a);
    bus_if.addr[i*18 +: 18] = a;
  endtask

  task automatic set_wdata(input int i, input logic [7:0] d);
    bus_if.wdata[i*8 +: 8] = d;
  endtask

  task automatic clear_inputs();
    bus_if.req   = '0;
    bus_if.lock  = '0;
    bus_if.we    = '0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    check({tag, "_gnt"},   32'(bus_if.gnt), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_enb"},   32'(ram_enb), 32'd0);
    check({tag, "_owner"}, 32'(owner_id), 32'd0);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e_gnt, e_rv, e_rd;
    int drop_k;

    mem[18'h00010] = 8'hA5;
    mem[18'h00100] = 8'h11;
    mem[18'h00101] = 8'h22;
    p1 = '0;
    p2 = '0;

    // Reset state
    do_reset("rst0");
    check("rst0_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    check("rst0_err_hold", 32'(err_hold), 32'd0);

    // 1) single read by requester 0
    for (int k = 0; k < 6; k++) begin
      bus_if.req = (k < 2) ? 4'b0001 : 4'b0000;
      set_addr(0, 18'h00010);
      #1;
      e_gnt = (k == 1) ? 32'h1 : 32'h0;
      e_rv  = (k == 4) ? 32'h1 : 32'h0;
      check($sformatf("t1_gnt_k%0d", k), 32'(bus_if.gnt), e_gnt);
      check($sformatf("t1_rv_k%0d", k), 32'(bus_if.rd_valid), e_rv);
      if (k == 1) check("t1_busy", 32'(busy), 32'd1);
      if (k == 2) begin
        check("t1_enb", 32'(ram_enb), 32'd1);
        check("t1_web", 32'(ram_web), 32'd0);
        check("t1_addrb", 32'(ram_addrb), 32'h10);
      end
      if (k == 4) check("t1_rd_data", 32'(bus_if.rd_data), 32'hA5);
      @(posedge clk);
      #1;
    end

    // 2) all four requesting, no lock: 0,1,2,3,0 with a bubble between owners
    do_reset("rst1");
    for (int k = 0; k < 11; k++) begin
      bus_if.req = (k < 10) ? 4'b1111 : 4'b0000;
      #1;
      e_gnt = (k % 2 == 1) ? (32'h1 << (((k - 1) / 2) % 4)) : 32'h0;
      check($sformatf("t2_gnt_k%0d", k), 32'(bus_if.gnt), e_gnt);
      check($sformatf("t2_busy_k%0d", k), 32'(busy), (k % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    repeat (5) step();

    // 3) locked write burst by 1 while 2 waits, then locked readback by 2
    for (int k = 0; k < 14; k++) begin
      bus_if.we = 4'b0010;
      bus_if.req[1] = (k < 5);
      bus_if.req[2] = (k < 10);
      if (k >= 1 && k <= 4) begin
        set_addr(1, 18'h00200 + 18'(k - 1));
        set_wdata(1, 8'(k - 1));
      end else if (k == 0) begin
        set_addr(1, 18'h00200);
        set_wdata(1, 8'h00);
      end
      bus_if.lock[1] = (k < 4);
      if (k <= 6) set_addr(2, 18'h00200);
      else if (k <= 9) set_addr(2, 18'h00200 + 18'(k - 6));
      bus_if.lock[2] = (k < 9);
      #1;
      e_gnt = (k >= 1 && k <= 4) ? 32'h2 : (k >= 6 && k <= 9) ? 32'h4 : 32'h0;
      e_rv  = (k >= 9 && k <= 12) ? 32'h4 : 32'h0;
      check($sformatf("t3_gnt_k%0d", k), 32'(bus_if.gnt), e_gnt);
      check($sformatf("t3_rv_k%0d", k), 32'(bus_if.rd_valid), e_rv);
      if (k >= 9 && k <= 12) begin
        e_rd = 32'(k - 9);
        check($sformatf("t3_rdata_k%0d", k), 32'(bus_if.rd_data), e_rd);
      end
      if (k >= 2 && k <= 5) begin
        check($sformatf("t3_web_k%0d", k), 32'(ram_web), 32'd1);
        check($sformatf("t3_addrb_k%0d", k), 32'(ram_addrb), 32'h200 + 32'(k - 2));
        check($sformatf("t3_dinb_k%0d", k), 32'(ram_dinb), 32'(k - 2));
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();

    // 4) read by 0 then read by 1; tags survive the owner change
    for (int k = 0; k < 8; k++) begin
      bus_if.req[0] = (k < 2);
      bus_if.req[1] = (k < 4);
      set_addr(0, 18'h00100);
      set_addr(1, 18'h00101);
      #1;
      e_gnt = (k == 1) ? 32'h1 : (k == 3) ? 32'h2 : 32'h0;
      e_rv  = (k == 4) ? 32'h1 : (k == 6) ? 32'h2 : 32'h0;
      check($sformatf("t4_gnt_k%0d", k), 32'(bus_if.gnt), e_gnt);
      check($sformatf("t4_rv_k%0d", k), 32'(bus_if.rd_valid), e_rv);
      if (k == 4) check("t4_rdata0", 32'(bus_if.rd_data), 32'h11);
      if (k == 6) check("t4_rdata1", 32'(bus_if.rd_data), 32'h22);
      if (k == 3) check("t4_owner", 32'(owner_id), 32'd1);
      @(posedge clk);
      #1;
    end
    clear_inputs();

    // 5) async reset in the middle of a locked read burst by 3
    for (int k = 0; k < 11; k++) begin
      if (k < 4) begin
        bus_if.req  = 4'b1000;
        bus_if.lock = 4'b1000;
        set_addr(3, 18'h00010);
      end else begin
        clear_inputs();
      end
      if (k == 4) rst_n = 1'b0;
      if (k == 6) rst_n = 1'b1;
      #1;
      if (k >= 1 && k <= 3) check($sformatf("t5_gnt_k%0d", k), 32'(bus_if.gnt), 32'h8);
      if (k == 4) begin
        check("t5_rst_gnt", 32'(bus_if.gnt), 32'd0);
        check("t5_rst_rdata", 32'(bus_if.rd_data), 32'd0);
        check("t5_rst_enb", 32'(ram_enb), 32'd0);
        check("t5_rst_addrb", 32'(ram_addrb), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_owner", 32'(owner_id), 32'd0);
        check("t5_rst_err", 32'(err_hold), 32'd0);
      end
      if (k >= 4) check($sformatf("t5_rv_k%0d", k), 32'(bus_if.rd_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // 6) requester 0 holds lock with 3 waiting; watchdog (if built) forces release
`ifdef ARB_WATCHDOG_EN
    drop_k = 7;
`else
    drop_k = 8;
`endif
    for (int k = 0; k < 11; k++) begin
      bus_if.req  = (k < drop_k) ? 4'b1001 : 4'b0000;
      bus_if.lock = 4'b0001;
      set_addr(0, 18'h00010);
      set_addr(3, 18'h00010);
      #1;
`ifdef ARB_WATCHDOG_EN
      e_gnt = (k >= 1 && k <= 4) ? 32'h1 : (k == 6) ? 32'h8 : 32'h0;
      e_rv  = (k == 5) ? 32'd1 : 32'd0;
`else
      e_gnt = (k >= 1 && k < drop_k) ? 32'h1 : 32'h0;
      e_rv  = 32'd0;
`endif
      check($sformatf("t6_gnt_k%0d", k), 32'(bus_if.gnt), e_gnt);
      check($sformatf("t6_err_k%0d", k), 32'(err_hold), e_rv);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
